// File: rtl/dispatch_buffer_if.sv
// Entry type carried from rename/dispatch to the ALU reservation station, and the
// handshake bundle between dispatch, the dispatch buffer and the RS.
package dispatch_pkg;
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [6:0]  prd;
        logic [6:0]  prs1;
        logic [6:0]  prs2;
        logic [3:0]  alu_op;
        logic        use_imm;
        logic [31:0] imm;
    } dispatch_pipeline_data;
endpackage

interface dispatch_buffer_if #(
    parameter int DEPTH = 4
);
    import dispatch_pkg::*;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  valid_in;
    logic                  ready_in;
    dispatch_pipeline_data data_in;
    logic                  valid_out;
    logic                  ready_out;
    dispatch_pipeline_data data_out;
    logic [CNT_W-1:0]      count;

    modport slave (
        input  flush, valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, count
    );

    modport master (
        output flush, valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, count
    );
endinterface

// File: rtl/dispatch_buffer.sv
// Elastic in-order FIFO between dispatch and the ALU RS: 1-cycle push-to-output latency,
// no bypass; ready_in/valid_out decode only the registered count, flush drops all entries.
module dispatch_buffer
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    dispatch_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    dispatch_pipeline_data storage_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_in;
    logic             valid_out;
    logic             push;
    logic             pop;

    assign ready_in      = (count_q != CNT_W'(DEPTH));
    assign valid_out     = (count_q != '0);
    assign push          = bus.valid_in & ready_in;
    assign pop           = valid_out & bus.ready_out;

    assign bus.ready_in  = ready_in;
    assign bus.valid_out = valid_out;
    assign bus.data_out  = storage_q[rd_ptr_q];
    assign bus.count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush wins over any handshake seen in the same cycle.
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            storage_q[wr_ptr_q] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_dispatch_buffer.sv
// Scenario bench for dispatch_buffer: a negedge scoreboard checks ordering and occupancy,
// each test task adds its own scenario-specific checks.
module tb_dispatch_buffer;
    import dispatch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    dispatch_buffer_if #(.DEPTH(DEPTH)) bus ();

    dispatch_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    dispatch_pipeline_data sb [$];
    dispatch_pipeline_data exp_d;

    // Scoreboard: handshakes are observed mid-cycle, before the edge that commits them.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            checks++;
            if (bus.count !== CNT_W'(sb.size())) begin
                errors++;
                $display("FAIL sb_count got %0d exp %0d", bus.count, sb.size());
            end
            if (bus.flush) begin
                sb.delete();
            end else begin
                if (bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow got %h exp none", bus.data_out);
                    end else begin
                        exp_d = sb.pop_front();
                        if (bus.data_out !== exp_d) begin
                            errors++;
                            $display("FAIL sb_data got %h exp %h", bus.data_out, exp_d);
                        end
                    end
                end
                if (bus.ready_in === 1'b1 && bus.valid_in === 1'b1) begin
                    sb.push_back(bus.data_in);
                end
            end
        end
    end

    function automatic dispatch_pipeline_data rnd();
        return dispatch_pipeline_data'({$urandom(), $urandom()});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input dispatch_pipeline_data d);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.ready_out = 1'b1;
        repeat (n) tick();
        bus.ready_out = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus.count !== '0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", bus.count);
        end
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid_out got %b exp 0", bus.valid_out);
        end
        checks++;
        if (bus.ready_in !== 1'b1) begin
            errors++; $display("FAIL reset_ready_in got %b exp 1", bus.ready_in);
        end
    endtask

    task automatic test_fill_hold();
        dispatch_pipeline_data a, b, c;
        a = rnd(); b = rnd(); c = rnd();
        push_one(a); push_one(b); push_one(c);
        checks++;
        if (bus.count !== CNT_W'(3)) begin
            errors++; $display("FAIL hold_count got %0d exp 3", bus.count);
        end
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== a) begin
            errors++; $display("FAIL hold_head got %b/%h exp 1/%h", bus.valid_out, bus.data_out, a);
        end
        checks++;
        if (bus.ready_in !== 1'b1) begin
            errors++; $display("FAIL hold_ready_in got %b exp 1", bus.ready_in);
        end
        tick(); tick();
        checks++;
        if (bus.data_out !== a) begin
            errors++; $display("FAIL hold_stable got %h exp %h", bus.data_out, a);
        end
        drain(3);
        checks++;
        if (bus.count !== '0) begin
            errors++; $display("FAIL hold_drain got %0d exp 0", bus.count);
        end
    endtask

    task automatic test_full();
        dispatch_pipeline_data d [4];
        foreach (d[i]) begin
            d[i] = rnd();
            push_one(d[i]);
        end
        checks++;
        if (bus.count !== CNT_W'(DEPTH) || bus.ready_in !== 1'b0) begin
            errors++; $display("FAIL full_state got %0d/%b exp 4/0", bus.count, bus.ready_in);
        end
        push_one(rnd());
        checks++;
        if (bus.count !== CNT_W'(DEPTH)) begin
            errors++; $display("FAIL full_overflow got %0d exp 4", bus.count);
        end
        bus.ready_out = 1'b1;
        checks++;
        if (bus.ready_in !== 1'b0) begin
            errors++; $display("FAIL full_same_cycle got %b exp 0", bus.ready_in);
        end
        tick();
        bus.ready_out = 1'b0;
        checks++;
        if (bus.ready_in !== 1'b1 || bus.count !== CNT_W'(3)) begin
            errors++; $display("FAIL full_after_pop got %b/%0d exp 1/3", bus.ready_in, bus.count);
        end
        checks++;
        if (bus.data_out !== d[1]) begin
            errors++; $display("FAIL full_head got %h exp %h", bus.data_out, d[1]);
        end
        drain(3);
    endtask

    task automatic test_back_to_back();
        push_one(rnd()); push_one(rnd());
        bus.valid_in  = 1'b1;
        bus.ready_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.data_in = rnd();
            tick();
            checks++;
            if (bus.count !== CNT_W'(2)) begin
                errors++; $display("FAIL b2b_count cycle %0d got %0d exp 2", i, bus.count);
            end
        end
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        drain(2);
    endtask

    task automatic test_latency();
        dispatch_pipeline_data x;
        x = rnd();
        bus.valid_in = 1'b1;
        bus.data_in  = x;
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++; $display("FAIL lat_before got %b exp 0", bus.valid_out);
        end
        tick();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== x) begin
            errors++; $display("FAIL lat_after got %b/%h exp 1/%h", bus.valid_out, bus.data_out, x);
        end
        drain(1);
    endtask

    task automatic test_flush();
        dispatch_pipeline_data g;
        push_one(rnd()); push_one(rnd()); push_one(rnd());
        bus.flush     = 1'b1;
        bus.valid_in  = 1'b1;
        bus.data_in   = rnd();
        bus.ready_out = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        checks++;
        if (bus.count !== '0 || bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1) begin
            errors++;
            $display("FAIL flush_state got %0d/%b/%b exp 0/0/1", bus.count, bus.valid_out, bus.ready_in);
        end
        g = rnd();
        push_one(g);
        checks++;
        if (bus.data_out !== g) begin
            errors++; $display("FAIL flush_next got %h exp %h", bus.data_out, g);
        end
        drain(1);
    endtask

    task automatic test_reset_mid();
        dispatch_pipeline_data y;
        push_one(rnd()); push_one(rnd());
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.count !== '0) begin
            errors++; $display("FAIL async_reset got %b/%0d exp 0/0", bus.valid_out, bus.count);
        end
        tick();
        reset = 1'b0;
        y = rnd();
        push_one(y);
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== y) begin
            errors++; $display("FAIL reset_push got %b/%h exp 1/%h", bus.valid_out, bus.data_out, y);
        end
        drain(1);
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        bus.data_in   = '0;
        test_reset();
        test_fill_hold();
        test_full();
        test_back_to_back();
        test_latency();
        test_flush();
        test_reset_mid();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
